lsu_axi_master: RTL
===================

Name: lsu_axi_master

Overview:
- AXI4-Lite-style initiator for the load/store unit (LSU). It turns one LSU memory request at a time into the data-side handshake (d_araddr/d_arvalid/d_rready, d_awaddr/d_awvalid, d_wdata/d_wstrb/d_wvalid, d_bready) consumed by the SRAM responder.
- It requests the shared bus from the arbiter and drives the channel valids only while it holds DATAMEM_GRANT.
- It returns load data or store completion to the LSU with an error code.

Parameters:
- DATA_WIDTH, 32, address and data width (matches `DATA_WIDTH).
- WMASK_LENGTH, 4, write-strobe width (matches `WMASK_LENGTH).
- ACERR_WIDTH, 2, response-code width (matches `ACERR_WIDTH).
- TIMEOUT_CYCLES, 256, watchdog limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSU request valid.
- req_ready  out  1  master can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_wstrb  in  WMASK_LENGTH  store byte strobes.
- resp_valid  out  1  response available.
- resp_ready  in  1  LSU accepts response.
- resp_rdata  out  DATA_WIDTH  load data (0 for stores).
- resp_err  out  ACERR_WIDTH  rresp/bresp, or timeout code.
- arb_req  out  1  bus request to arbiter.
- grant  in  `NUM_ARB_MASTERS  arbiter grant vector.
- d_araddr  out  DATA_WIDTH  read address.
- d_arvalid  out  1  read address valid.
- aready  in  1  read address ready.
- rdata  in  DATA_WIDTH  read data.
- rresp  in  ACERR_WIDTH  read response.
- rvalid  in  1  read data valid.
- d_rready  out  1  read data ready.
- d_awaddr  out  DATA_WIDTH  write address.
- d_awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- d_wdata  out  DATA_WIDTH  write data.
- d_wstrb  out  WMASK_LENGTH  write strobes.
- d_wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bresp  in  ACERR_WIDTH  write response.
- bvalid  in  1  write response valid.
- d_bready  out  1  write response ready.

Behaviour:
- Reset (rstn low, async):
  - state=IDLE.
  - All valids/readies, arb_req and resp_valid are 0.
  - resp_rdata, resp_err, addr/data/strb registers are 0.
  - Reset mid-transaction abandons it immediately: no response is issued and all valids drop in the same instant.
- FSM states: IDLE, ARB, RADDR, RDATA, WRITE, WRESP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/wdata/wstrb/we; next state ARB.
  - req_ready=0 in all other states (one outstanding request).
- ARB:
  - arb_req=1; arb_req stays 1 through RADDR/RDATA/WRITE/WRESP.
  - When grant==`DATAMEM_GRANT, go to RADDR if load, else WRITE.
- RADDR:
  - d_arvalid=1 with stable d_araddr.
  - On arvalid&&aready, drop arvalid and go to RDATA.
- RDATA:
  - d_rready=1.
  - On rvalid, capture rdata→resp_rdata and rresp→resp_err; go to RESP.
- WRITE:
  - d_awvalid and d_wvalid are asserted together.
  - Each valid drops independently after its own handshake (AW and W may complete in the same or different cycles).
  - When both are done, go to WRESP.
- WRESP:
  - d_bready=1.
  - On bvalid, capture bresp→resp_err and set resp_rdata=0; go to RESP.
- RESP:
  - arb_req=0; resp_valid=1, with outputs held stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE.
- Minimum latency with immediate grant/ready:
  - Load: accept→resp_valid in 4 cycles.
  - Store: accept→resp_valid in 3 cycles.
- Grant loss: if grant deasserts before a handshake completes, the active valids drop and the FSM returns to ARB without losing progress flags. The W/AW-done flags are retained.
- Boundaries:
  - Holding valids until the handshake tolerates aready/awready being high before valid.
  - rvalid arriving in the same cycle as the AR handshake is ignored until RDATA.
  - resp_ready may be held permanently high.
  - A store with req_wstrb=0 is still issued.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro:
  - A counter runs in RADDR/RDATA/WRITE/WRESP and clears on entering ARB from IDLE.
  - When it reaches TIMEOUT_CYCLES, all valids drop, resp_err=2'b11 (DECERR), resp_rdata=0, and the FSM goes to RESP.
- Without the macro: no counter; the master waits indefinitely.

Decomposition:
- Shared package: FSM state enum; response codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11; grant encodings (`EMPTY_GRANT, `INSTMEM_GRANT, `DATAMEM_GRANT, `UART_GRANT); width macros.
- One natural sub-module: lsu_axi_wr_chan, which tracks the AW/W independent-handshake done flags and the valid drive.

Test Plan:
- Load, immediate grant and readies: addr 0x8000_0010, memory word 0xDEAD_BEEF → resp_rdata=0xDEAD_BEEF, resp_err=0, resp_valid 4 cycles after accept.
- Store with AW ready 3 cycles before W ready: addr 0x8000_0020, data 0x1234_5678, wstrb 4'b0011 → d_awvalid drops first, d_wvalid later; one bresp; resp_err=0, resp_rdata=0.
- Grant withheld 10 cycles (`INSTMEM_GRANT held) → d_arvalid stays 0 and arb_req stays 1; load completes after `DATAMEM_GRANT.
- Back-to-back requests with resp_ready low 5 cycles → req_ready=0 and resp fields stable throughout; second request accepted only after the response handshake.
- Reset asserted during WRESP → all outputs 0 asynchronously; after release, a new load completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid never asserted → resp_err=2'b11 17 cycles after entering RADDR, then return to IDLE.

Source files
------------

// File: rtl/lsu_axi_master_pkg.sv
// rtl/lsu_axi_master_pkg.sv - shared widths, grant encodings, FSM states and response codes for the LSU AXI master
`ifndef LSU_AXI_MASTER_DEFS
`define LSU_AXI_MASTER_DEFS
`define DATA_WIDTH      32
`define WMASK_LENGTH    4
`define ACERR_WIDTH     2
`define NUM_ARB_MASTERS 3
`define EMPTY_GRANT     3'b000
`define INSTMEM_GRANT   3'b001
`define DATAMEM_GRANT   3'b010
`define UART_GRANT      3'b100
`endif

package lsu_axi_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_RADDR,
      ST_RDATA,
      ST_WRITE,
      ST_WRESP,
      ST_RESP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/lsu_axi_master_if.sv
// rtl/lsu_axi_master_if.sv - LSU request/response, arbiter and data-bus signals of the LSU AXI master
interface lsu_axi_master_if #(
   parameter int DATA_WIDTH   = `DATA_WIDTH,
   parameter int WMASK_LENGTH = `WMASK_LENGTH,
   parameter int ACERR_WIDTH  = `ACERR_WIDTH
);
   logic                         req_valid;
   logic                         req_ready;
   logic                         req_we;
   logic [DATA_WIDTH-1:0]        req_addr;
   logic [DATA_WIDTH-1:0]        req_wdata;
   logic [WMASK_LENGTH-1:0]      req_wstrb;
   logic                         resp_valid;
   logic                         resp_ready;
   logic [DATA_WIDTH-1:0]        resp_rdata;
   logic [ACERR_WIDTH-1:0]       resp_err;
   logic                         arb_req;
   logic [`NUM_ARB_MASTERS-1:0]  grant;
   logic [DATA_WIDTH-1:0]        d_araddr;
   logic                         d_arvalid;
   logic                         aready;
   logic [DATA_WIDTH-1:0]        rdata;
   logic [ACERR_WIDTH-1:0]       rresp;
   logic                         rvalid;
   logic                         d_rready;
   logic [DATA_WIDTH-1:0]        d_awaddr;
   logic                         d_awvalid;
   logic                         awready;
   logic [DATA_WIDTH-1:0]        d_wdata;
   logic [WMASK_LENGTH-1:0]      d_wstrb;
   logic                         d_wvalid;
   logic                         wready;
   logic [ACERR_WIDTH-1:0]       bresp;
   logic                         bvalid;
   logic                         d_bready;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready, grant,
             aready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
      output req_ready, resp_valid, resp_rdata, resp_err, arb_req,
             d_araddr, d_arvalid, d_rready, d_awaddr, d_awvalid,
             d_wdata, d_wstrb, d_wvalid, d_bready
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready, grant,
             aready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
      input  req_ready, resp_valid, resp_rdata, resp_err, arb_req,
             d_araddr, d_arvalid, d_rready, d_awaddr, d_awvalid,
             d_wdata, d_wstrb, d_wvalid, d_bready
   );
endinterface

// File: rtl/lsu_axi_wr_chan.sv
// rtl/lsu_axi_wr_chan.sv - AW/W valid drive with independent per-channel handshake-done flags
module lsu_axi_wr_chan (
   input  logic clk,
   input  logic rstn,
   input  logic clear_i,
   input  logic active_i,
   input  logic awready_i,
   input  logic wready_i,
   output logic awvalid_o,
   output logic wvalid_o,
   output logic all_done_q_o,
   output logic all_done_d_o
);
   logic aw_done_q, aw_done_d;
   logic w_done_q, w_done_d;

   // Each valid stays up until its own handshake; done flags survive grant loss until the next request
   always_comb begin
      awvalid_o    = active_i && !aw_done_q;
      wvalid_o     = active_i && !w_done_q;
      aw_done_d    = aw_done_q || (awvalid_o && awready_i);
      w_done_d     = w_done_q || (wvalid_o && wready_i);
      all_done_d_o = aw_done_d && w_done_d;
      all_done_q_o = aw_done_q && w_done_q;
      if (clear_i) begin
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end
   end

   // Done-flag registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end
endmodule

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - LSU AXI4-Lite-style initiator; define LSU_TIMEOUT_EN to enable the watchdog
module lsu_axi_master #(
   parameter int DATA_WIDTH     = `DATA_WIDTH,
   parameter int WMASK_LENGTH   = `WMASK_LENGTH,
   parameter int ACERR_WIDTH    = `ACERR_WIDTH,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic              clk,
   input logic              rstn,
   lsu_axi_master_if.master bus
);
   import lsu_axi_master_pkg::*;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [WMASK_LENGTH-1:0] wstrb_q, wstrb_d;
   logic [ACERR_WIDTH-1:0]  err_q, err_d;
   logic                    we_q, we_d;
   logic                    ar_done_q, ar_done_d;
   logic                    granted, timeout_hit;
   logic                    wr_active, wr_clear, wr_awvalid, wr_wvalid;
   logic                    wr_all_done_q, wr_all_done_d;

   assign granted = (bus.grant == `DATAMEM_GRANT);

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_run;

   assign tmo_run     = state_q inside {ST_RADDR, ST_RDATA, ST_WRITE, ST_WRESP};
   assign timeout_hit = tmo_run && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

   // Watchdog: zeroed while idle so each request starts fresh, counts only while a channel is in flight
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == ST_IDLE) begin
         tmo_cnt_d = '0;
      end else if (tmo_run && !timeout_hit) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^{TIMEOUT_CYCLES, RESP_DECERR};
   assign timeout_hit    = 1'b0;
`endif

   assign wr_active = (state_q == ST_WRITE) && granted && !timeout_hit;

   lsu_axi_wr_chan u_wr_chan (
      .clk          (clk),
      .rstn         (rstn),
      .clear_i      (wr_clear),
      .active_i     (wr_active),
      .awready_i    (bus.awready),
      .wready_i     (bus.wready),
      .awvalid_o    (wr_awvalid),
      .wvalid_o     (wr_wvalid),
      .all_done_q_o (wr_all_done_q),
      .all_done_d_o (wr_all_done_d)
   );

   // Channel drive is gated by the grant so valids vanish the moment the bus is lost
   assign bus.req_ready  = (state_q == ST_IDLE) && rstn;
   assign bus.arb_req    = state_q inside {ST_ARB, ST_RADDR, ST_RDATA, ST_WRITE, ST_WRESP};
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.d_araddr   = addr_q;
   assign bus.d_arvalid  = (state_q == ST_RADDR) && granted && !timeout_hit;
   assign bus.d_rready   = (state_q == ST_RDATA) && granted && !timeout_hit;
   assign bus.d_awaddr   = addr_q;
   assign bus.d_awvalid  = wr_awvalid;
   assign bus.d_wdata    = wdata_q;
   assign bus.d_wstrb    = wstrb_q;
   assign bus.d_wvalid   = wr_wvalid;
   // B is already accepted in the cycle the last of AW/W completes, saving a cycle on stores
   assign bus.d_bready   = granted && !timeout_hit &&
                           ((state_q == ST_WRESP) || ((state_q == ST_WRITE) && wr_all_done_d));

   // Next-state and register updates; a watchdog expiry overrides whatever the state decided
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      we_d      = we_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      ar_done_d = ar_done_q;
      wr_clear  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               addr_d    = bus.req_addr;
               wdata_d   = bus.req_wdata;
               wstrb_d   = bus.req_wstrb;
               we_d      = bus.req_we;
               ar_done_d = 1'b0;
               wr_clear  = 1'b1;
               state_d   = ST_ARB;
            end
         end
         ST_ARB: begin
            if (granted) begin
               if (!we_q) begin
                  state_d = ar_done_q ? ST_RDATA : ST_RADDR;
               end else begin
                  state_d = wr_all_done_q ? ST_WRESP : ST_WRITE;
               end
            end
         end
         ST_RADDR: begin
            if (!granted) begin
               state_d = ST_ARB;
            end else if (bus.aready) begin
               ar_done_d = 1'b1;
               state_d   = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (!granted) begin
               state_d = ST_ARB;
            end else if (bus.rvalid) begin
               rdata_d = bus.rdata;
               err_d   = bus.rresp;
               state_d = ST_RESP;
            end
         end
         ST_WRITE: begin
            if (!granted) begin
               state_d = ST_ARB;
            end else if (wr_all_done_d) begin
               if (bus.bvalid) begin
                  rdata_d = '0;
                  err_d   = bus.bresp;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WRESP;
               end
            end
         end
         ST_WRESP: begin
            if (!granted) begin
               state_d = ST_ARB;
            end else if (bus.bvalid) begin
               rdata_d = '0;
               err_d   = bus.bresp;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (timeout_hit) begin
         rdata_d = '0;
         err_d   = ACERR_WIDTH'(RESP_DECERR);
         state_d = ST_RESP;
      end
   end

   // FSM state and request/response registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
         err_q     <= ACERR_WIDTH'(RESP_OKAY);
         ar_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         ar_done_q <= ar_done_d;
      end
   end
endmodule
